// File: rtl/alarm_pkg.sv
// Shared types and constants for the intrusion-alarm sequencer.
// State codes are externally visible on STATE, so their values are fixed.
package alarm_pkg;

    localparam int TICK_W = 18;
    localparam int CAD_W  = 16;

    typedef logic [TICK_W-1:0] tick_t;
    typedef logic [CAD_W-1:0]  cad_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXIT_DLY  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_ENTRY_DLY = 3'd3,
        ST_ALARM     = 3'd4,
        ST_SILENCED  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        KEY_OK    = 2'd0,
        KEY_ERROR = 2'd2,
        NO_KEY    = 2'd3
    } key_status_t;

    // States that run the shared delay counter
    function automatic logic is_timed(input state_t s);
        return (s == ST_EXIT_DLY) || (s == ST_ENTRY_DLY) || (s == ST_ALARM);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
// Both stages clear on synchronous active-low reset.
module sync_2ff (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Keypad/sensor alarm sequencer: exit/entry delays, alarm with cadenced siren,
// auto-silence and re-trigger. One shared 18-bit delay counter.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | disarmed, waiting for a valid code to arm
// ST_EXIT_DLY  | exit delay running, sensors ignored
// ST_ARMED     | armed, watching sensors and wrong-code attempts
// ST_ENTRY_DLY | door opened, entry delay running before alarm
// ST_ALARM     | siren cadencing until disarm or max duration
// ST_SILENCED  | siren timed out, any new sensor opening re-alarms
import alarm_pkg::*;

module alarm_sequencer #(
    parameter int EXIT_TICKS      = 150000,
    parameter int ENTRY_TICKS     = 150000,
    parameter int SIREN_MAX_TICKS = 262143,
    parameter int SIREN_ON_TICKS  = 5000,
    parameter int SIREN_OFF_TICKS = 5000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ARM_REQ,
    input  logic              DISARM_REQ,
    input  logic              KEY_FAIL,
    input  logic              SENSOR_DOOR,
    input  logic              SENSOR_WIN,
    output logic [2:0]        STATE,
    output logic              SIREN_OUT,
    output logic [TICK_W-1:0] REMAIN
);

    localparam tick_t EXIT_LOAD  = tick_t'(EXIT_TICKS - 1);
    localparam tick_t ENTRY_LOAD = tick_t'(ENTRY_TICKS - 1);
    localparam tick_t ALARM_LOAD = tick_t'(SIREN_MAX_TICKS - 1);
    localparam cad_t  ON_LAST    = cad_t'(SIREN_ON_TICKS - 1);
    localparam cad_t  OFF_LAST   = cad_t'(SIREN_OFF_TICKS - 1);

    state_t      state_q, state_d;
    tick_t       cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d;
    cad_t        cad_q, cad_d;
    logic        siren_q, siren_d;

    logic        door_s, win_s;
    logic        door_prev, win_prev;

    key_status_t key_st;
    logic        expiry;
    logic        fail_inc;
    logic [1:0]  fail_sat;
    logic        lockout;
    logic        sensor_rise;
    logic        entering;

    sync_2ff u_sync_door (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (SENSOR_DOOR),
        .q     (door_s)
    );

    sync_2ff u_sync_win (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (SENSOR_WIN),
        .q     (win_s)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            fail_q    <= '0;
            cad_q     <= '0;
            siren_q   <= 1'b0;
            door_prev <= 1'b0;
            win_prev  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            cad_q     <= cad_d;
            siren_q   <= siren_d;
            door_prev <= door_s;
            win_prev  <= win_s;
        end
    end

    // A valid disarm code in the same cycle as a wrong code counts as correct
    always_comb begin
        key_st = NO_KEY;
        if (DISARM_REQ) begin
            key_st = KEY_OK;
        end else if (KEY_FAIL) begin
            key_st = KEY_ERROR;
        end
    end

    always_comb begin
        expiry      = is_timed(state_q) && (cnt_q == '0);
        fail_inc    = (key_st == KEY_ERROR) &&
                      ((state_q == ST_ARMED) || (state_q == ST_ENTRY_DLY));
        fail_sat    = (fail_inc && (fail_q != 2'd3)) ? fail_q + 2'd1 : fail_q;
        lockout     = (fail_sat == 2'd3);
        sensor_rise = (door_s & ~door_prev) | (win_s & ~win_prev);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ARM_REQ) state_d = ST_EXIT_DLY;
            end
            ST_EXIT_DLY: begin
                if (DISARM_REQ)  state_d = ST_IDLE;
                else if (expiry) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (DISARM_REQ)   state_d = ST_IDLE;
                else if (win_s)   state_d = ST_ALARM;
                else if (lockout) state_d = ST_ALARM;
                else if (door_s)  state_d = ST_ENTRY_DLY;
            end
            ST_ENTRY_DLY: begin
                if (DISARM_REQ)   state_d = ST_IDLE;
                else if (expiry)  state_d = ST_ALARM;
                else if (win_s)   state_d = ST_ALARM;
                else if (lockout) state_d = ST_ALARM;
            end
            ST_ALARM: begin
                if (DISARM_REQ)  state_d = ST_IDLE;
                else if (expiry) state_d = ST_SILENCED;
            end
            ST_SILENCED: begin
                if (DISARM_REQ)       state_d = ST_IDLE;
                else if (sensor_rise) state_d = ST_ALARM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        entering = (state_d != state_q);
        cnt_d    = '0;
        if (entering && (state_d == ST_EXIT_DLY)) begin
            cnt_d = EXIT_LOAD;
        end else if (entering && (state_d == ST_ENTRY_DLY)) begin
            cnt_d = ENTRY_LOAD;
        end else if (entering && (state_d == ST_ALARM)) begin
            cnt_d = ALARM_LOAD;
        end else if (is_timed(state_d) && (cnt_q != '0)) begin
            cnt_d = cnt_q - tick_t'(1);
        end
    end

    always_comb begin
        fail_d = (state_d == ST_IDLE) ? 2'd0 : fail_sat;
    end

    // Siren register doubles as the cadence phase: high = on-phase
    always_comb begin
        siren_d = 1'b0;
        cad_d   = '0;
        if (state_d == ST_ALARM) begin
            if (entering) begin
                siren_d = 1'b1;
            end else if (siren_q) begin
                siren_d = (cad_q != ON_LAST);
                cad_d   = (cad_q == ON_LAST) ? '0 : cad_q + cad_t'(1);
            end else begin
                siren_d = (cad_q == OFF_LAST);
                cad_d   = (cad_q == OFF_LAST) ? '0 : cad_q + cad_t'(1);
            end
        end
    end

    assign STATE     = state_q;
    assign SIREN_OUT = siren_q;
    assign REMAIN    = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Randomised scoreboard bench for alarm_sequencer with a cycle-age reference model.
// Stimulus pushes expected outputs; a monitor pops and compares after each edge.
module tb_alarm_sequencer;

    localparam int EXIT_T  = 4;
    localparam int ENTRY_T = 6;
    localparam int SMAX_T  = 20;
    localparam int ON_T    = 3;
    localparam int OFF_T   = 2;

    typedef struct packed {
        logic [2:0]  st;
        logic        siren;
        logic [17:0] remain;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        arm_req, disarm_req, key_fail, sensor_door, sensor_win;
    logic [2:0]  state;
    logic        siren;
    logic [17:0] remain;

    exp_t sb_q[$];
    exp_t last_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_cyc  = 0;

    // reference model: state, cycles spent in current state, wrong-code tally
    int m_st, m_age, m_fails;
    bit dh0, dh1, dprev, wh0, wh1, wprev;

    alarm_sequencer #(
        .EXIT_TICKS      (EXIT_T),
        .ENTRY_TICKS     (ENTRY_T),
        .SIREN_MAX_TICKS (SMAX_T),
        .SIREN_ON_TICKS  (ON_T),
        .SIREN_OFF_TICKS (OFF_T)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ARM_REQ     (arm_req),
        .DISARM_REQ  (disarm_req),
        .KEY_FAIL    (key_fail),
        .SENSOR_DOOR (sensor_door),
        .SENSOR_WIN  (sensor_win),
        .STATE       (state),
        .SIREN_OUT   (siren),
        .REMAIN      (remain)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dur(input int s);
        case (s)
            1: return EXIT_T;
            3: return ENTRY_T;
            4: return SMAX_T;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit arm, input bit dis, input bit kf,
                              input bit door, input bit win, input bit rst,
                              output exp_t e);
        bit ds, ws, rise, expiry, lock;
        int nf, nx;
        if (rst) begin
            m_st = 0; m_age = 0; m_fails = 0;
            dh0 = 0; dh1 = 0; dprev = 0; wh0 = 0; wh1 = 0; wprev = 0;
            e = '0;
        end else begin
            ds     = dh1;
            ws     = wh1;
            rise   = (ds && !dprev) || (ws && !wprev);
            expiry = (dur(m_st) > 0) && (m_age == dur(m_st) - 1);
            nf     = m_fails;
            if (kf && !dis && (m_st == 2 || m_st == 3) && nf < 3) nf = nf + 1;
            lock   = (nf == 3);
            nx     = m_st;
            case (m_st)
                0: if (arm) nx = 1;
                1: if (dis) nx = 0; else if (expiry) nx = 2;
                2: if (dis) nx = 0; else if (ws || lock) nx = 4; else if (ds) nx = 3;
                3: if (dis) nx = 0; else if (expiry || ws || lock) nx = 4;
                4: if (dis) nx = 0; else if (expiry) nx = 5;
                5: if (dis) nx = 0; else if (rise) nx = 4;
                default: nx = 0;
            endcase
            m_age   = (nx == m_st) ? m_age + 1 : 0;
            m_fails = (nx == 0) ? 0 : nf;
            m_st    = nx;
            dprev = ds; dh1 = dh0; dh0 = door;
            wprev = ws; wh1 = wh0; wh0 = win;
            e.st     = 3'(nx);
            e.remain = (dur(nx) > 0) ? 18'(dur(nx) - 1 - m_age) : 18'd0;
            e.siren  = (nx == 4) && ((m_age % (ON_T + OFF_T)) < ON_T);
        end
    endtask

    task automatic drive(input bit arm, input bit dis, input bit kf,
                         input bit door, input bit win, input bit rst);
        exp_t e;
        @(negedge clk);
        arm_req     = arm;
        disarm_req  = dis;
        key_fail    = kf;
        sensor_door = door;
        sensor_win  = win;
        rst_n       = !rst;
        model_step(arm, dis, kf, door, win, rst, e);
        sb_q.push_back(e);
        last_e = e;
        n_cyc++;
    endtask

    task automatic idle(input int n, input bit door, input bit win);
        for (int i = 0; i < n; i++) drive(0, 0, 0, door, win, 0);
    endtask

    // monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                n_vec++;
                if (state !== x.st || siren !== x.siren || remain !== x.remain) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d: state got %0d want %0d, siren got %0b want %0b, remain got %0d want %0d",
                             n_vec, state, x.st, siren, x.siren, remain, x.remain);
                end
            end
        end
    end

    initial begin
        int guard;
        bit door_l, win_l;
        arm_req = 0; disarm_req = 0; key_fail = 0;
        sensor_door = 0; sensor_win = 0; rst_n = 0;

        drive(0, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 1, 1, 1);
        idle(2, 0, 0);

        // arm, exit delay, door-triggered entry delay, alarm, silence, re-trigger
        drive(1, 0, 0, 0, 0, 0);
        idle(6, 0, 0);
        idle(40, 1, 0);
        idle(3, 0, 0);
        idle(6, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        idle(3, 0, 0);

        // wrong-code lockout
        drive(1, 0, 0, 0, 0, 0);
        idle(5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            idle(1, 0, 0);
        end
        idle(2, 0, 0);
        drive(0, 1, 0, 0, 0, 0);

        // wrong code together with disarm clears the tally
        drive(1, 0, 0, 0, 0, 0);
        idle(5, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle(5, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(3, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(2, 0, 0);
        drive(0, 1, 0, 0, 0, 0);

        // disarm on the very cycle the entry delay expires
        drive(1, 0, 0, 0, 0, 0);
        idle(5, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        guard = 0;
        while (!(last_e.st == 3'd3 && last_e.remain == 18'd0) && guard < 20) begin
            idle(1, 0, 0);
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_fail++;
            $display("FAIL entry_expiry_wait: model never reached ENTRY_DLY remain 0 within 20 cycles");
        end
        drive(0, 1, 0, 0, 0, 0);
        idle(2, 0, 0);

        // window opened only during exit delay is ignored
        drive(1, 0, 0, 0, 0, 0);
        idle(2, 0, 1);
        idle(8, 0, 0);
        drive(0, 1, 0, 0, 0, 0);

        // reset in the middle of an alarm with sensors held open
        drive(1, 0, 0, 0, 0, 0);
        idle(5, 0, 0);
        idle(8, 1, 1);
        drive(0, 0, 0, 1, 1, 1);
        idle(10, 1, 1);
        idle(3, 0, 0);

        // randomised traffic
        door_l = 0;
        win_l  = 0;
        for (int i = 0; i < 4000; i++) begin
            bit a, d, k, r;
            a = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 39) == 0);
            k = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 24) == 0) door_l = !door_l;
            if ($urandom_range(0, 39) == 0) win_l = !win_l;
            drive(a, d, k, door_l, win_l, r);
        end
        idle(3, 0, 0);

        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
